// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: round-robin write sequencer with setup/open/hold windows for a bank of D latches
module latch_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int NENT = 4,
  parameter int DW = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC = 2,
  parameter int HOLD_CYC = 1,
  localparam int AW = NENT > 1 ? $clog2(NENT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [DW-1:0]        latch_d,
  output logic [NENT-1:0]      latch_en,
  output logic                 busy
);
  localparam int IW = $clog2(NREQ);
  localparam int SC = SETUP_CYC < 1 ? 1 : SETUP_CYC;
  localparam int OC = OPEN_CYC < 1 ? 1 : OPEN_CYC;
  localparam int HC = HOLD_CYC < 1 ? 1 : HOLD_CYC;
  localparam int MC = SC > OC ? (SC > HC ? SC : HC) : (OC > HC ? OC : HC);
  localparam int CW = MC > 1 ? $clog2(MC) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] win, win_n, rr, rr_n, pick, idx;
  logic [AW-1:0] addr, addr_n;
  logic [DW-1:0] data_n;
  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] data_a [NREQ];
  logic last;
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*AW +: AW];
    assign data_a[i] = req_data[i*DW +: DW];
  end
  assign last = cnt == '0;
  // Round-robin pick: first requester at or above rr, wrapping; descending scan lets the nearest win
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr) + k) % NREQ);
      if (req[idx]) pick = idx;
    end
  end
  // Next-state logic; the phase counter is reloaded on every phase entry and counts down to zero
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    win_n = win;
    addr_n = addr;
    data_n = latch_d;
    rr_n = rr;
    case (state)
      IDLE: if (|req) begin
        state_n = SETUP;
        cnt_n = CW'(SC - 1);
        win_n = pick;
        addr_n = addr_a[pick];
        data_n = data_a[pick];
      end
      SETUP: begin
        state_n = last ? OPEN : SETUP;
        cnt_n = last ? CW'(OC - 1) : cnt - 1'b1;
      end
      OPEN: begin
        state_n = last ? HOLD : OPEN;
        cnt_n = last ? CW'(HC - 1) : cnt - 1'b1;
      end
      HOLD: begin
        state_n = last ? IDLE : HOLD;
        cnt_n = last ? cnt : cnt - 1'b1;
        rr_n = last ? (win == IW'(NREQ - 1) ? '0 : win + 1'b1) : rr;
      end
    endcase
  end
  // State and captured transaction registers; the captured data register is the latch data bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      win <= '0;
      rr <= '0;
      addr <= '0;
      latch_d <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      win <= win_n;
      rr <= rr_n;
      addr <= addr_n;
      latch_d <= data_n;
    end
  end
  // Outputs are registered from next-state values so latch_en never sees decode glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt <= '0;
      done <= '0;
      err <= 1'b0;
      latch_en <= '0;
      busy <= 1'b0;
    end else begin
      gnt <= state_n != IDLE ? NREQ'(1) << win_n : '0;
      done <= state_n == HOLD && cnt_n == '0 ? NREQ'(1) << win_n : '0;
      err <= state_n == HOLD && cnt_n == '0 && int'(addr_n) >= NENT;
      latch_en <= state_n == OPEN && int'(addr_n) < NENT ? NENT'(1) << addr_n : '0;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb_latch_bank_arbiter: vector table plus corner-case sequences for latch_bank_arbiter
module tb_latch_bank_arbiter;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  logic [3:0] req0, gnt0, done0, en0, req1, gnt1, done1, req2, gnt2, done2, en2;
  logic [7:0] addr0, addr1, addr2, ld0, ld1, ld2;
  logic [31:0] data0, data1, data2;
  logic [2:0] en1;
  logic err0, err1, err2, busy0, busy1, busy2;
  localparam logic [7:0] A0 = 8'b00_11_10_01;
  localparam logic [31:0] D0 = 32'h3CA52211;
  latch_bank_arbiter d0 (.clk(clk), .reset(reset), .req(req0), .req_addr(addr0), .req_data(data0),
    .gnt(gnt0), .done(done0), .err(err0), .latch_d(ld0), .latch_en(en0), .busy(busy0));
  latch_bank_arbiter #(.NENT(3)) d1 (.clk(clk), .reset(reset), .req(req1), .req_addr(addr1), .req_data(data1),
    .gnt(gnt1), .done(done1), .err(err1), .latch_d(ld1), .latch_en(en1), .busy(busy1));
  latch_bank_arbiter #(.SETUP_CYC(2), .OPEN_CYC(1), .HOLD_CYC(3)) d2 (.clk(clk), .reset(reset), .req(req2),
    .req_addr(addr2), .req_data(data2), .gnt(gnt2), .done(done2), .err(err2), .latch_d(ld2), .latch_en(en2),
    .busy(busy2));
  int pass = 0;
  int total = 0;
  logic [3:0] sb [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // Invariants on d0: one-hot latch enable, latch_d frozen across a whole transaction
  logic prev_busy = 0;
  logic [7:0] prev_d = 0;
  always @(negedge clk) begin
    if (reset) prev_busy <= 0;
    else begin
      chk("onehot_en", 32'($onehot0(en0)), 1);
      if (prev_busy && busy0) chk("d_stable", ld0, prev_d);
      prev_busy <= busy0;
      prev_d <= ld0;
    end
  end
  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] en;
    logic [7:0] d;
  } vec_t;
  vec_t tv [6];
  initial begin
    tv[0] = '{4'b0100, 4'b0100, 4'b1000, 8'hA5};
    tv[1] = '{4'b0011, 4'b0001, 4'b0010, 8'h11};
    tv[2] = '{4'b0011, 4'b0010, 4'b0100, 8'h22};
    tv[3] = '{4'b1001, 4'b1000, 4'b0001, 8'h3C};
    tv[4] = '{4'b1001, 4'b0001, 4'b0010, 8'h11};
    tv[5] = '{4'b0001, 4'b0001, 4'b0010, 8'h11};
    req0 = 0; addr0 = A0; data0 = D0;
    req1 = 0; addr1 = 8'b00_00_11_00; data1 = 32'h00005A00;
    req2 = 0; addr2 = 8'b00_00_00_10; data2 = 32'h00000077;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_gnt", gnt0, 0); chk("rst_busy", busy0, 0); chk("rst_en", en0, 0);
    chk("rst_d", ld0, 0); chk("rst_done", done0, 0); chk("rst_err", err0, 0);
    for (int v = 0; v < 6; v++) begin
      req0 = tv[v].req;
      sb.push_back(tv[v].gnt);
      @(negedge clk);
      req0 = 0;
      chk("setup_gnt", gnt0, tv[v].gnt); chk("setup_d", ld0, tv[v].d);
      chk("setup_en", en0, 0); chk("setup_busy", busy0, 1);
      for (int s = 0; s < 2; s++) begin
        data0 = 32'hFFFFFFFF; addr0 = 0;
        @(negedge clk);
        chk("open_en", en0, tv[v].en); chk("open_d", ld0, tv[v].d);
      end
      @(negedge clk);
      chk("hold_en", en0, 0); chk("hold_d", ld0, tv[v].d); chk("hold_err", err0, 0);
      chk("hold_done", done0, sb.pop_front());
      addr0 = A0; data0 = D0;
      @(negedge clk);
      chk("idle_gnt", gnt0, 0); chk("idle_busy", busy0, 0); chk("idle_done", done0, 0);
    end
    req0 = 4'b0001;
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    chk("pre_rst_en", en0, 4'b0010);
    #2 reset = 1;
    #1 chk("async_en", en0, 0); chk("async_gnt", gnt0, 0); chk("async_busy", busy0, 0);
    @(negedge clk);
    reset = 0;
    req0 = 4'b1010;
    @(negedge clk);
    req0 = 0;
    chk("rst_rr_gnt", gnt0, 4'b0010);
    for (int c = 0; c < 10 && done0 == 0; c++) @(negedge clk);
    chk("rst_rr_done", done0, 4'b0010);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    sb.push_back(4'b0001); sb.push_back(4'b0010); sb.push_back(4'b0100);
    sb.push_back(4'b1000); sb.push_back(4'b0001);
    req0 = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("rr_gnt", gnt0, sb[0]);
      repeat (3) @(negedge clk);
      chk("rr_done", done0, sb.pop_front());
      @(negedge clk);
      chk("rr_idle", gnt0, 0);
    end
    req0 = 0;
    @(negedge clk);
    req1 = 4'b0010;
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
      req1 = 0;
      if (s == 1) chk("oor_gnt", gnt1, 4'b0010);
      chk("oor_en", en1, 0);
      chk("oor_done", done1, s == 4 ? 4'b0010 : 4'b0000);
      chk("oor_err", err1, s == 4 ? 1 : 0);
      chk("oor_busy", busy1, s < 5 ? 1 : 0);
    end
    req2 = 4'b0001;
    for (int s = 1; s <= 7; s++) begin
      @(negedge clk);
      req2 = 0;
      chk("sweep_en", en2, s == 3 ? 4'b0100 : 4'b0000);
      chk("sweep_done", done2, s == 6 ? 4'b0001 : 4'b0000);
      chk("sweep_busy", busy2, s < 7 ? 1 : 0);
      chk("sweep_d", ld2, 8'h77);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
